if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the riscv_cpu pipeline, directly upstream of the ID stage. Keeps the fetch PC, drives a single-outstanding request/grant/rvalid instruction-memory port, and holds the fetched instruction plus its PC in the IF/ID register. Takes redirects (JAL/JALR, branch) from later stages and squashes wrong-path fetches. Stalls without loss when ID is not ready.

## Interface
- BOOT_ADDR, 32'h0000_0000: first fetch address after reset; must be 4-byte aligned.
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous reset, active-high
- instr_req_o  out  1  memory request valid
- instr_addr_o  out  32  request address, word aligned
- instr_gnt_i  in  1  memory accepted request this cycle
- instr_rvalid_i  in  1  response data valid this cycle
- instr_rdata_i  in  32  response data
- pc_mux_i  in  2  next-PC select: 00 PC_INCR, 01 PC_JAL, 10 PC_BRANCH, 11 treated as PC_INCR
- jal_addr_i  in  32  JAL/JALR target
- branch_addr_i  in  32  branch target
- stall_i  in  1  ID cannot accept; hold IF/ID register
- instr_rdata_id_o  out  32  instruction to ID (registered)
- pc_id_o  out  32  PC of instr_rdata_id_o (registered)
- instr_valid_id_o  out  1  IF/ID register holds a valid instruction

## Operation
- States: REQ (request driven, waiting for gnt), WAIT (granted, waiting for rvalid), IDLE (no request).
- instr_req_o = 1 exactly in REQ, and in WAIT/IDLE in the cycle the issue condition holds (combinational issue), with instr_addr_o = fetch_pc.
- Issue condition: slot_free = ~instr_valid_id_o | ~stall_i, and no response outstanding (or it arrives this cycle).
- REQ: instr_addr_o must not change until gnt, even on redirect. gnt -> WAIT, fetch_pc += 4 (mod 2^32, wraps 0xFFFF_FFFC -> 0).
- WAIT: on rvalid, if discard flag clear: instr_rdata_id_o <= instr_rdata_i, pc_id_o <= address of that request, instr_valid_id_o <= 1. Same cycle: if slot_free issue the next request (gnt -> stay WAIT, no gnt -> REQ), else -> IDLE.
- IDLE: enter REQ/WAIT once slot_free.
- Consume: instr_valid_id_o & ~stall_i with no new data -> instr_valid_id_o <= 0 next cycle.
- Redirect: pc_mux_i ∈ {01,10} while instr_valid_id_o = 1. Effects next edge: fetch_pc <= selected target; instr_valid_id_o <= 0; if in REQ or WAIT, discard flag <= 1 and the outstanding response is dropped (rvalid clears discard flag, slot not written). Redirect has priority over stall_i and over an rvalid in the same cycle.
- Request issued during redirect cycle uses the new target; the old fetch_pc address is never issued after a redirect unless it is already held in REQ.
- Redirect while pc_mux_i valid but instr_valid_id_o = 0: ignored.
- Misaligned target: bits [1:0] forced to 00.

## Timing
- Reset (async assert, outputs immediate): instr_req_o 0, instr_addr_o BOOT_ADDR, instr_rdata_id_o 0, pc_id_o 0, instr_valid_id_o 0, discard 0, fetch_pc BOOT_ADDR, state REQ-pending.
- First request in first cycle after rst_i deasserts, address BOOT_ADDR.
- Latency: gnt at cycle N, rvalid at N+k (k ≥ 1) -> instr_valid_id_o high from N+k+1.
- Zero-wait memory (gnt same cycle, rvalid next): throughput 1 instruction/cycle.
- Redirect at cycle R: first target request at R+1 at earliest; wrong-path instructions never reach ID.
- Reset mid-transaction: outstanding response after reset is not expected; memory must be reset with the core.

## Test plan
- Reset release, zero-wait memory returning addr as data: requests at 0x0,0x4,0x8 on consecutive cycles; instr_valid_id_o high from cycle 2 with pc_id_o 0x0,0x4,0x8 each cycle.
- gnt delayed 3 cycles, addr 0x10: instr_addr_o stays 0x10 for all 4 request cycles; single entry pc_id_o=0x10.
- stall_i high 5 cycles with valid slot: instr_rdata_id_o/pc_id_o frozen, at most one request issued before slot drains, no instruction lost or duplicated after release.
- pc_mux_i=01, jal_addr_i=0x100 while fetch of 0x8 outstanding: rvalid for 0x8 discarded, next pc_id_o=0x100, instr_valid_id_o low for the bubble cycles.
- pc_mux_i=10, branch_addr_i=0x203 with simultaneous rvalid and stall_i: redirect wins, next request 0x200, stale data dropped.
- BOOT_ADDR=0xFFFF_FFF8, sequential: fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; asynchronous rst_i mid-WAIT: outputs reset immediately, restart at BOOT_ADDR.

Source files
------------

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage
//  Purpose  : Instruction-fetch stage. Holds the fetch PC, drives a single-
//             outstanding req/gnt/rvalid instruction-memory port and the
//             IF/ID register. Redirects squash wrong-path fetches; a stalled
//             ID stage never loses an instruction.
//  Ports    :
//     clk_i, rst_i        clock, asynchronous active-high reset
//     instr_req_o         memory request valid
//     instr_addr_o        request address (word aligned)
//     instr_gnt_i         request accepted this cycle
//     instr_rvalid_i      response valid this cycle
//     instr_rdata_i       response data
//     pc_mux_i            next-PC select (00/11 incr, 01 jal, 10 branch)
//     jal_addr_i          JAL/JALR target
//     branch_addr_i       branch target
//     stall_i             ID cannot accept; hold IF/ID register
//     instr_rdata_id_o    instruction to ID
//     pc_id_o             PC of instr_rdata_id_o
//     instr_valid_id_o    IF/ID register valid
//  Revision : 1.0  initial release
// ============================================================================
module if_stage #(
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        instr_req_o,
   output logic [31:0] instr_addr_o,
   input  logic        instr_gnt_i,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   input  logic [1:0]  pc_mux_i,
   input  logic [31:0] jal_addr_i,
   input  logic [31:0] branch_addr_i,
   input  logic        stall_i,
   output logic [31:0] instr_rdata_id_o,
   output logic [31:0] pc_id_o,
   output logic        instr_valid_id_o
);

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_IDLE = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] fetch_pc, fetch_pc_nxt;   // next address to be issued
   logic [31:0] req_addr, req_addr_nxt;   // address of request in REQ/WAIT
   logic        discard, discard_nxt;

   // One-entry skid: catches the single in-flight response that can land
   // while ID is stalled on an occupied slot.
   logic        skid_valid;
   logic [31:0] skid_rdata;
   logic [31:0] skid_pc;

   logic [31:0] target_raw;
   logic [31:0] target;
   logic        redirect;
   logic        slot_free;
   logic        resp_keep;
   logic        issue;

   assign target_raw = (pc_mux_i == 2'b01) ? jal_addr_i : branch_addr_i;
   assign target     = {target_raw[31:2], 2'b00};
   assign redirect   = instr_valid_id_o & ((pc_mux_i == 2'b01) | (pc_mux_i == 2'b10));
   assign slot_free  = ~instr_valid_id_o | ~stall_i;
   assign resp_keep  = (state == ST_WAIT) & instr_rvalid_i & ~discard & ~redirect;

   // ------------------------------------------------------------------------
   // Fetch FSM: next state, issue decision, PC bookkeeping
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      req_addr_nxt = req_addr;
      discard_nxt  = discard;
      issue        = 1'b0;

      case (state)
         ST_REQ: begin
            if (instr_gnt_i)
               state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (instr_rvalid_i) begin
               discard_nxt = 1'b0;
               // Redirect blocks issue: the first target fetch goes out a cycle later.
               if (slot_free & ~redirect)
                  issue = 1'b1;
               else
                  state_nxt = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (slot_free & ~redirect)
               issue = 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (issue) begin
         state_nxt    = instr_gnt_i ? ST_WAIT : ST_REQ;
         req_addr_nxt = fetch_pc;
         fetch_pc_nxt = fetch_pc + 32'd4;
      end

      if (redirect) begin
         fetch_pc_nxt = target;
         // A request still in REQ, or one awaiting its response, is wrong-path.
         if ((state == ST_REQ) || ((state == ST_WAIT) && !instr_rvalid_i))
            discard_nxt = 1'b1;
      end
   end

   // The REQ state is held through reset, so the request is masked there.
   assign instr_req_o  = ~rst_i & ((state == ST_REQ) | issue);
   assign instr_addr_o = (state == ST_REQ) ? req_addr : fetch_pc;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= ST_REQ;
         req_addr <= BOOT_ADDR;
         fetch_pc <= BOOT_ADDR + 32'd4;
         discard  <= 1'b0;
      end else begin
         state    <= state_nxt;
         req_addr <= req_addr_nxt;
         fetch_pc <= fetch_pc_nxt;
         discard  <= discard_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // IF/ID register and skid entry
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         instr_rdata_id_o <= 32'd0;
         pc_id_o          <= 32'd0;
         instr_valid_id_o <= 1'b0;
         skid_valid       <= 1'b0;
         skid_rdata       <= 32'd0;
         skid_pc          <= 32'd0;
      end else if (redirect) begin
         instr_valid_id_o <= 1'b0;
         skid_valid       <= 1'b0;
      end else if (resp_keep && slot_free) begin
         instr_rdata_id_o <= instr_rdata_i;
         pc_id_o          <= req_addr;
         instr_valid_id_o <= 1'b1;
      end else if (resp_keep) begin
         skid_rdata <= instr_rdata_i;
         skid_pc    <= req_addr;
         skid_valid <= 1'b1;
      end else if (!stall_i) begin
         if (skid_valid) begin
            instr_rdata_id_o <= skid_rdata;
            pc_id_o          <= skid_pc;
            skid_valid       <= 1'b0;
         end else begin
            instr_valid_id_o <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_stage
//  Purpose  : Directed bench for if_stage. Per-cycle vectors drive the memory
//             handshake and redirect inputs; expected request/IF-ID outputs
//             are hand-computed. A second instance with a high boot address
//             covers PC wrap and asynchronous reset mid-transaction.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_stage;

   localparam logic [31:0] DMASK = 32'h1300_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        gnt = 1'b0;
   logic        rvalid = 1'b0;
   logic [31:0] rdata = 32'd0;
   logic [1:0]  mux = 2'b00;
   logic [31:0] jal = 32'd0;
   logic [31:0] br = 32'd0;
   logic        stall = 1'b0;

   logic        req0, req1, val0, val1;
   logic [31:0] addr0, addr1, ins0, ins1, pc0, pc1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   if_stage #(.BOOT_ADDR(32'h0000_0000)) dut (
      .clk_i(clk), .rst_i(rst),
      .instr_req_o(req0), .instr_addr_o(addr0),
      .instr_gnt_i(gnt), .instr_rvalid_i(rvalid), .instr_rdata_i(rdata),
      .pc_mux_i(mux), .jal_addr_i(jal), .branch_addr_i(br), .stall_i(stall),
      .instr_rdata_id_o(ins0), .pc_id_o(pc0), .instr_valid_id_o(val0)
   );

   if_stage #(.BOOT_ADDR(32'hFFFF_FFF8)) dut_hi (
      .clk_i(clk), .rst_i(rst),
      .instr_req_o(req1), .instr_addr_o(addr1),
      .instr_gnt_i(gnt), .instr_rvalid_i(rvalid), .instr_rdata_i(rdata),
      .pc_mux_i(mux), .jal_addr_i(jal), .branch_addr_i(br), .stall_i(stall),
      .instr_rdata_id_o(ins1), .pc_id_o(pc1), .instr_valid_id_o(val1)
   );

   typedef struct {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rd;      // address whose data memory returns (data = rd ^ DMASK)
      logic        stall;
      logic [1:0]  mux;
      logic [31:0] jal;
      logic [31:0] br;
      logic        req;     // expected outputs during this cycle
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
   } vec_t;

   vec_t va[$];
   vec_t vb[$];

   function automatic vec_t v(input logic g, input logic r, input logic [31:0] rd,
                              input logic s, input logic [1:0] m, input logic [31:0] j,
                              input logic [31:0] b, input logic q, input logic [31:0] a,
                              input logic vl, input logic [31:0] p);
      vec_t t;
      t.gnt = g; t.rvalid = r; t.rd = rd; t.stall = s; t.mux = m; t.jal = j; t.br = b;
      t.req = q; t.addr = a; t.valid = vl; t.pc = p;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle at the negedge, compare 1 time unit later, move to next negedge.
   task automatic apply(input vec_t t, input int sel, input int idx);
      logic        q, vl;
      logic [31:0] a, p, d;
      gnt = t.gnt; rvalid = t.rvalid; rdata = t.rd ^ DMASK; stall = t.stall;
      mux = t.mux; jal = t.jal; br = t.br;
      #1;
      if (sel == 0) begin q = req0; a = addr0; vl = val0; p = pc0; d = ins0; end
      else          begin q = req1; a = addr1; vl = val1; p = pc1; d = ins1; end
      chk($sformatf("t%0d c%0d req", sel, idx), {31'd0, q}, {31'd0, t.req});
      if (t.req) chk($sformatf("t%0d c%0d addr", sel, idx), a, t.addr);
      chk($sformatf("t%0d c%0d valid", sel, idx), {31'd0, vl}, {31'd0, t.valid});
      if (t.valid) begin
         chk($sformatf("t%0d c%0d pc_id", sel, idx), p, t.pc);
         chk($sformatf("t%0d c%0d instr", sel, idx), d, t.pc ^ DMASK);
      end
      @(negedge clk);
   endtask

   task automatic chk_reset(input string name);
      chk({name, " req0"}, {31'd0, req0}, 32'd0);
      chk({name, " addr0"}, addr0, 32'h0000_0000);
      chk({name, " valid0"}, {31'd0, val0}, 32'd0);
      chk({name, " pc0"}, pc0, 32'd0);
      chk({name, " ins0"}, ins0, 32'd0);
      chk({name, " req1"}, {31'd0, req1}, 32'd0);
      chk({name, " addr1"}, addr1, 32'hFFFF_FFF8);
      chk({name, " valid1"}, {31'd0, val1}, 32'd0);
      chk({name, " pc1"}, pc1, 32'd0);
   endtask

   initial begin
      //          gnt rv rd            st mux   jal          br            req addr          vld pc
      // zero-wait streaming from reset
      va.push_back(v(1,0,32'h0,   0,2'd0,32'h0,  32'h0,   1,32'h0,  0,32'h0));
      va.push_back(v(1,1,32'h0,   0,2'd0,32'h0,  32'h0,   1,32'h4,  0,32'h0));
      va.push_back(v(1,1,32'h4,   0,2'd0,32'h0,  32'h0,   1,32'h8,  1,32'h0));
      va.push_back(v(1,1,32'h8,   0,2'd0,32'h0,  32'h0,   1,32'hC,  1,32'h4));
      // grant for 0x10 delayed three cycles
      va.push_back(v(0,1,32'hC,   0,2'd0,32'h0,  32'h0,   1,32'h10, 1,32'h8));
      va.push_back(v(0,0,32'h0,   0,2'd0,32'h0,  32'h0,   1,32'h10, 1,32'hC));
      va.push_back(v(0,0,32'h0,   0,2'd0,32'h0,  32'h0,   1,32'h10, 0,32'h0));
      va.push_back(v(1,0,32'h0,   0,2'd0,32'h0,  32'h0,   1,32'h10, 0,32'h0));
      va.push_back(v(1,1,32'h10,  0,2'd0,32'h0,  32'h0,   1,32'h14, 0,32'h0));
      // five-cycle stall with a response in flight
      va.push_back(v(0,1,32'h14,  1,2'd0,32'h0,  32'h0,   0,32'h0,  1,32'h10));
      va.push_back(v(0,0,32'h0,   1,2'd0,32'h0,  32'h0,   0,32'h0,  1,32'h10));
      va.push_back(v(0,0,32'h0,   1,2'd0,32'h0,  32'h0,   0,32'h0,  1,32'h10));
      va.push_back(v(0,0,32'h0,   1,2'd0,32'h0,  32'h0,   0,32'h0,  1,32'h10));
      va.push_back(v(0,0,32'h0,   1,2'd0,32'h0,  32'h0,   0,32'h0,  1,32'h10));
      va.push_back(v(1,0,32'h0,   0,2'd0,32'h0,  32'h0,   1,32'h18, 1,32'h10));
      va.push_back(v(1,1,32'h18,  0,2'd0,32'h0,  32'h0,   1,32'h1C, 1,32'h14));
      // JAL to 0x100 while the fetch of 0x1C is outstanding
      va.push_back(v(0,0,32'h0,   0,2'd1,32'h100,32'h0,   0,32'h0,  1,32'h18));
      va.push_back(v(1,1,32'h1C,  0,2'd0,32'h0,  32'h0,   1,32'h100,0,32'h0));
      va.push_back(v(0,1,32'h100, 0,2'd0,32'h0,  32'h0,   1,32'h104,0,32'h0));
      va.push_back(v(1,0,32'h0,   1,2'd0,32'h0,  32'h0,   1,32'h104,1,32'h100));
      // branch to misaligned 0x203 with simultaneous rvalid and stall
      va.push_back(v(0,1,32'h104, 1,2'd2,32'h0,  32'h203, 0,32'h0,  1,32'h100));
      va.push_back(v(1,0,32'h0,   0,2'd0,32'h0,  32'h0,   1,32'h200,0,32'h0));
      va.push_back(v(1,1,32'h200, 0,2'd0,32'h0,  32'h0,   1,32'h204,0,32'h0));
      va.push_back(v(0,0,32'h0,   0,2'd0,32'h0,  32'h0,   0,32'h0,  1,32'h200));
      // redirect with empty slot is ignored
      va.push_back(v(0,0,32'h0,   0,2'd1,32'h300,32'h0,   0,32'h0,  0,32'h0));
      va.push_back(v(0,1,32'h204, 0,2'd0,32'h0,  32'h0,   1,32'h208,0,32'h0));
      // redirect while held in REQ: address held, response dropped
      va.push_back(v(0,0,32'h0,   0,2'd1,32'h400,32'h0,   1,32'h208,1,32'h204));
      va.push_back(v(1,0,32'h0,   0,2'd0,32'h0,  32'h0,   1,32'h208,0,32'h0));
      va.push_back(v(1,1,32'h208, 0,2'd0,32'h0,  32'h0,   1,32'h400,0,32'h0));
      va.push_back(v(0,1,32'h400, 0,2'd0,32'h0,  32'h0,   1,32'h404,0,32'h0));
      // pc_mux 11 behaves as increment
      va.push_back(v(1,0,32'h0,   0,2'd3,32'h500,32'h600, 1,32'h404,1,32'h400));
      va.push_back(v(1,1,32'h404, 0,2'd0,32'h0,  32'h0,   1,32'h408,0,32'h0));
      va.push_back(v(0,0,32'h0,   0,2'd0,32'h0,  32'h0,   0,32'h0,  1,32'h404));

      // high boot address: wrap across zero
      vb.push_back(v(1,0,32'h0,         0,2'd0,32'h0,32'h0, 1,32'hFFFF_FFF8,0,32'h0));
      vb.push_back(v(1,1,32'hFFFF_FFF8, 0,2'd0,32'h0,32'h0, 1,32'hFFFF_FFFC,0,32'h0));
      vb.push_back(v(1,1,32'hFFFF_FFFC, 0,2'd0,32'h0,32'h0, 1,32'h0,        1,32'hFFFF_FFF8));
      vb.push_back(v(0,0,32'h0,         0,2'd0,32'h0,32'h0, 0,32'h0,        1,32'hFFFF_FFFC));
      // after the mid-WAIT reset
      vb.push_back(v(1,0,32'h0,         0,2'd0,32'h0,32'h0, 1,32'hFFFF_FFF8,0,32'h0));
      vb.push_back(v(0,1,32'hFFFF_FFF8, 0,2'd0,32'h0,32'h0, 1,32'hFFFF_FFFC,0,32'h0));
      vb.push_back(v(0,0,32'h0,         0,2'd0,32'h0,32'h0, 1,32'hFFFF_FFFC,1,32'hFFFF_FFF8));

      #1 rst = 1'b1;
      #2 chk_reset("reset_async");
      @(posedge clk); #1 chk_reset("reset_held");

      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < va.size(); i++) apply(va[i], 0, i);

      // asynchronous reset while dut waits for a response
      gnt = 1'b0; rvalid = 1'b0; mux = 2'b00; stall = 1'b0;
      #2 rst = 1'b1;
      #1 chk_reset("reset_mid_wait_a");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) apply(vb[i], 1, i);

      // dut_hi is in WAIT for 0x0 here; reset it between clock edges
      gnt = 1'b0; rvalid = 1'b0;
      #2 rst = 1'b1;
      #1 chk_reset("reset_mid_wait_b");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 4; i < vb.size(); i++) apply(vb[i], 1, i);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
